dmem_pipe: RTL and testbench

DMEM_PIPE -- requirements
Module: dmem_pipe

---
 rtl/dmem_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_dmem_pipe.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_pipe.sv
// -----------------------------------------------------------------------------
// dmem_pipe -- pipelined data memory with valid/ready request and response
// channels.
//
// Requests are accepted on valid_i && ready_o. Writes commit and reads sample
// the array at the accepting edge. Each response appears LATENCY cycles later.
// Responses that the consumer stalls are parked in an internal FIFO, so none is
// dropped. An outstanding counter (accepted minus consumed) throttles ready_o.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous reset, active low
//   valid_i  in   request valid
//   ready_o  out  request accept, (count < MAX_OUTST), registered state only
//   we_i     in   1 = write, 0 = read
//   be_i     in   byte-lane write enables
//   addr_i   in   byte address, bits [1:0] ignored for indexing
//   wdata_i  in   write data
//   valid_o  out  response valid
//   ready_i  in   response consumer ready
//   rdata_o  out  read data (0 for writes, errors and idle cycles)
//   err_o    out  out-of-range request
//   we_o     out  response belongs to a write
// -----------------------------------------------------------------------------
package riscv_32im_pkg;
    parameter int unsigned DMEM_SIZE_BYTES = 1024;
    parameter logic [31:0] MAP_DMEM_BASE   = 32'h1000_0000;
endpackage

module dmem_pipe #(
    parameter int unsigned MEM_SIZE  = riscv_32im_pkg::DMEM_SIZE_BYTES,
    parameter logic [31:0] BASE_ADDR = riscv_32im_pkg::MAP_DMEM_BASE,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned MAX_OUTST = 4,
    parameter string       HEX_FILE  = ""
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        we_o
);

    localparam int unsigned WORDS = MEM_SIZE / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = 5;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("dmem_pipe: LATENCY must be within 1..4");
    end
    if (MAX_OUTST < LATENCY || MAX_OUTST > 16) begin : g_bad_max_outst
        $error("dmem_pipe: MAX_OUTST must be within LATENCY..16");
    end
    if (MEM_SIZE == 0 || (MEM_SIZE % 4) != 0) begin : g_bad_mem_size
        $error("dmem_pipe: MEM_SIZE must be a non-zero multiple of 4");
    end

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    // ---------------------------------------------------------------- decode
    logic             accept;
    logic             in_range;
    logic [29:0]      word_off;
    logic [IDX_W-1:0] word_idx;

    // A request arriving while reset is asserted is never accepted.
    assign accept   = valid_i && ready_o && rst_ni;
    assign word_off = addr_i[31:2] - BASE_ADDR[31:2];
    assign in_range = (addr_i >= BASE_ADDR) && ({2'b00, word_off} < WORDS);
    assign word_idx = word_off[IDX_W-1:0];

    // ---------------------------------------------------------------- memory
    logic [31:0] mem [WORDS];
    logic [31:0] mem_rdata_q;

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            mem[i] = '0;
        end
    end

    // Read-before-write: the read port returns the word as it was before this
    // edge; only a write request can touch the word at the same edge.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_rdata_q <= mem[word_idx];
            if (we_i && in_range) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // -------------------------------------------------------- latency stages
    // Stage 0 is loaded at the accepting edge; the last stage is what the
    // response port sees when nothing older is parked in the FIFO.
    logic [LATENCY-1:0] stg_vld_q, stg_vld_d;
    logic [LATENCY-1:0] stg_we_q,  stg_we_d;
    logic [LATENCY-1:0] stg_err_q, stg_err_d;
    logic [31:0]        stg_data [LATENCY];

    always_comb begin
        stg_vld_d    = '0;
        stg_we_d     = '0;
        stg_err_d    = '0;
        stg_vld_d[0] = accept;
        stg_we_d[0]  = accept && we_i;
        stg_err_d[0] = accept && !in_range;
        for (int i = 1; i < int'(LATENCY); i++) begin
            stg_vld_d[i] = stg_vld_q[i-1];
            stg_we_d[i]  = stg_we_q[i-1];
            stg_err_d[i] = stg_err_q[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < int'(LATENCY); gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // Only a valid in-range read carries the sampled word forward.
                assign stg_data[0] = (stg_vld_q[0] && !stg_we_q[0] && !stg_err_q[0])
                                   ? mem_rdata_q : '0;
            end else begin : g_next
                logic [31:0] data_q, data_d;
                assign data_d = stg_data[gi-1];
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        data_q <= '0;
                    end else begin
                        data_q <= data_d;
                    end
                end
                assign stg_data[gi] = data_q;
            end
        end
    endgenerate

    // ---------------------------------------------------------- stall FIFO
    rsp_t             fifo_mem [MAX_OUTST];
    rsp_t             last_rsp, head_rsp;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_empty, rsp_valid, consume, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign last_rsp = '{we: stg_we_q[LATENCY-1], err: stg_err_q[LATENCY-1],
                        data: stg_data[LATENCY-1]};

    always_comb begin
        fifo_empty = (fifo_cnt_q == '0);
        // Parked responses are older than the pipeline tail, so they go first.
        head_rsp   = fifo_empty ? last_rsp : fifo_mem[rd_ptr_q];
        rsp_valid  = !fifo_empty || stg_vld_q[LATENCY-1];
        consume    = rsp_valid && ready_i;
        pop        = consume && !fifo_empty;
        // The pipeline tail is parked unless it goes straight out this edge.
        push       = stg_vld_q[LATENCY-1] && !(fifo_empty && consume);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        count_d    = count_q + CNT_W'(accept) - CNT_W'(consume);
    end

    // FIFO payload needs no reset: occupancy is tracked by fifo_cnt_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= last_rsp;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_vld_q  <= '0;
            stg_we_q   <= '0;
            stg_err_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            count_q    <= '0;
        end else begin
            stg_vld_q  <= stg_vld_d;
            stg_we_q   <= stg_we_d;
            stg_err_q  <= stg_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            count_q    <= count_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign ready_o = (count_q < CNT_W'(MAX_OUTST));
    assign valid_o = rsp_valid;
    assign rdata_o = rsp_valid ? head_rsp.data : '0;
    assign err_o   = rsp_valid && head_rsp.err;
    assign we_o    = rsp_valid && head_rsp.we;

endmodule

// File: tb/tb_dmem_pipe.sv
// -----------------------------------------------------------------------------
// tb_dmem_pipe -- self-checking bench for dmem_pipe.
//
// A word-array model of memory plus a queue of expected responses (each tagged
// with the cycle at which it becomes due) predicts every response channel
// value. All driving and sampling happens at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dmem_pipe;

    localparam int unsigned MEM_SIZE = 1024;
    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam int unsigned LAT      = 2;
    localparam int unsigned MAXO     = 4;
    localparam int unsigned WORDS    = MEM_SIZE / 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        we_o;

    always #5 clk = ~clk;

    dmem_pipe #(
        .MEM_SIZE (MEM_SIZE),
        .BASE_ADDR(BASE),
        .LATENCY  (LAT),
        .MAX_OUTST(MAXO),
        .HEX_FILE ("")
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .we_i   (we_i),
        .be_i   (be_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .rdata_o(rdata_o),
        .err_o  (err_o),
        .we_o   (we_o)
    );

    typedef struct {
        int          due;
        bit          we;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [WORDS];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    function automatic bit ref_in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < WORDS);
    endfunction

    // One clock cycle: drive the request/ready for the coming edge, compare the
    // response port against the scoreboard, then update the model.
    task automatic step(input bit v, input bit w, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d, input bit rdy);
        bit   exp_v, exp_r, acc, cons;
        exp_t e;
        int   idx;
        valid_i = v; we_i = w; be_i = be; addr_i = a; wdata_i = d; ready_i = rdy;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        exp_r = (exp_q.size() < int'(MAXO));
        checks++;
        if (valid_o !== exp_v) begin
            errors++;
            $display("FAIL valid_o cyc=%0d got=%b exp=%b", cyc, valid_o, exp_v);
        end
        checks++;
        if (ready_o !== exp_r) begin
            errors++;
            $display("FAIL ready_o cyc=%0d got=%b exp=%b", cyc, ready_o, exp_r);
        end
        checks++;
        if (exp_v) begin
            if ({rdata_o, err_o, we_o} !== {exp_q[0].data, exp_q[0].err, exp_q[0].we}) begin
                errors++;
                $display("FAIL rsp cyc=%0d got data=%h err=%b we=%b exp data=%h err=%b we=%b",
                         cyc, rdata_o, err_o, we_o, exp_q[0].data, exp_q[0].err, exp_q[0].we);
            end
        end else if ({rdata_o, err_o, we_o} !== 34'd0) begin
            errors++;
            $display("FAIL idle_outputs cyc=%0d got data=%h err=%b we=%b exp all 0",
                     cyc, rdata_o, err_o, we_o);
        end
        cons = exp_v && rdy;
        acc  = v && exp_r;
        if (cons) begin
            $display("rsp  cyc=%0d we=%b err=%b data=%h", cyc, exp_q[0].we, exp_q[0].err,
                     exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (acc) begin
            e.due = cyc + int'(LAT);
            e.we  = w;
            e.err = !ref_in_range(a);
            idx   = int'((a - BASE) / 4);
            e.data = (!w && !e.err) ? ref_mem[idx] : 32'h0;
            if (w && !e.err) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
            exp_q.push_back(e);
            $display("req  cyc=%0d we=%b be=%h addr=%h wdata=%h", cyc, w, be, a, d);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_reset;
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({valid_o, rdata_o, err_o, we_o} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h e=%b w=%b exp all 0",
                     valid_o, rdata_o, err_o, we_o);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", ready_o);
        end
        idle(2);
    endtask

    task automatic test_write_read;
        step(1'b1, 1'b1, 4'hF, BASE, 32'hDEAD_BEEF, 1'b1);
        step(1'b1, 1'b0, 4'h0, BASE, 32'h0, 1'b1);
        // write accepted two cycles ago: write response now
        checks++;
        if ({valid_o, we_o, err_o, rdata_o} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL wr_rsp got v=%b we=%b err=%b d=%h exp v=1 we=1 err=0 d=0",
                     valid_o, we_o, err_o, rdata_o);
        end
        idle(1);
        checks++;
        if ({valid_o, we_o, rdata_o} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_rsp got v=%b we=%b d=%h exp v=1 we=0 d=deadbeef",
                     valid_o, we_o, rdata_o);
        end
        idle(2);
    endtask

    task automatic test_byte_lanes;
        step(1'b1, 1'b1, 4'b0010, BASE, 32'h0000_AA00, 1'b1);
        step(1'b1, 1'b0, 4'h0, BASE, 32'h0, 1'b1);
        idle(1);
        // only lane 1 (bits 15:8) of 0xDEADBEEF is replaced
        checks++;
        if ({valid_o, rdata_o} !== {1'b1, 32'hDEAD_AAEF}) begin
            errors++;
            $display("FAIL byte_lane got v=%b d=%h exp v=1 d=deadaaef", valid_o, rdata_o);
        end
        idle(2);
    endtask

    task automatic test_backpressure;
        int n_acc, n_rsp;
        for (int i = 1; i < 4; i++) step(1'b1, 1'b1, 4'hF, BASE + 4*i, 32'h1111_0000 + i, 1'b1);
        idle(4);
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (ready_o === 1'b1) n_acc++;
            step(1'b1, 1'b0, 4'h0, BASE + 4*i, 32'h0, 1'b0);
        end
        checks++;
        if (n_acc != 4) begin
            errors++;
            $display("FAIL bp_accepts got=%0d exp=4", n_acc);
        end
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_full got=%b exp=0", ready_o);
        end
        n_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid_o === 1'b1) n_rsp++;
            step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        end
        checks++;
        if (n_rsp != 4) begin
            errors++;
            $display("FAIL bp_responses got=%0d exp=4", n_rsp);
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_drained got=%b exp=1", ready_o);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] word0;
        word0 = ref_mem[0];
        step(1'b1, 1'b0, 4'h0, BASE + MEM_SIZE, 32'h0, 1'b1);
        idle(1);
        checks++;
        if ({valid_o, err_o, we_o, rdata_o} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL oor_read got v=%b err=%b we=%b d=%h exp v=1 err=1 we=0 d=0",
                     valid_o, err_o, we_o, rdata_o);
        end
        step(1'b1, 1'b1, 4'hF, BASE + MEM_SIZE, 32'hFFFF_FFFF, 1'b1);
        step(1'b1, 1'b1, 4'hF, BASE - 4, 32'hFFFF_FFFF, 1'b1);
        checks++;
        if ({valid_o, err_o, we_o, rdata_o} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL oor_write got v=%b err=%b we=%b d=%h exp v=1 err=1 we=1 d=0",
                     valid_o, err_o, we_o, rdata_o);
        end
        step(1'b1, 1'b0, 4'h0, BASE, 32'h0, 1'b1);
        idle(1);
        checks++;
        if ({valid_o, rdata_o} !== {1'b1, word0}) begin
            errors++;
            $display("FAIL oor_unchanged got v=%b d=%h exp v=1 d=%h", valid_o, rdata_o, word0);
        end
        // last in-range word
        step(1'b1, 1'b1, 4'hF, BASE + MEM_SIZE - 4, 32'hCAFE_F00D, 1'b1);
        step(1'b1, 1'b0, 4'h0, BASE + MEM_SIZE - 4, 32'h0, 1'b1);
        idle(3);
    endtask

    task automatic test_back_to_back;
        int c0, n_rsp, n_busy;
        c0 = cyc;
        n_rsp = 0;
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (cyc >= c0 + int'(LAT) && cyc < c0 + int'(LAT) + 16 && valid_o === 1'b1) n_rsp++;
            if (i < 16 && ready_o !== 1'b1) n_busy++;
            step(i < 16, 1'b0, 4'h0, BASE + 4*i, 32'h0, 1'b1);
        end
        checks++;
        if (n_rsp != 16) begin
            errors++;
            $display("FAIL b2b_responses got=%0d exp=16", n_rsp);
        end
        checks++;
        if (n_busy != 0) begin
            errors++;
            $display("FAIL b2b_ready_drops got=%0d exp=0", n_busy);
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        int          sel, guard;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0)      a = BASE + MEM_SIZE + 4 * $urandom_range(0, 7);
            else if (sel == 1) a = BASE - 4 * $urandom_range(1, 8);
            else               a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 a, $urandom, $urandom_range(0, 9) < 7);
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_reset_inflight;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, BASE + 4*i, 32'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_valid got=%b exp=1", valid_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_o, rdata_o, err_o, we_o} !== 35'd0) begin
            errors++;
            $display("FAIL rst_immediate got v=%b d=%h e=%b w=%b exp all 0",
                     valid_o, rdata_o, err_o, we_o);
        end
        // a write presented across an edge during reset must not commit
        valid_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = BASE + 8; wdata_i = 32'h1234_5678;
        @(negedge clk);
        cyc++;
        exp_q.delete();
        valid_i = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got=%b exp=1", ready_o);
        end
        idle(6);
        step(1'b1, 1'b0, 4'h0, BASE + 8, 32'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, BASE, 32'h0, 1'b1);
        idle(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = 32'h0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_backpressure();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
